// File: rtl/dlsc_axi_router_command_pkg.sv
// Shared helpers for the AXI router command stage: index-width computation
// and a packing macro for per-sink address windows.
`ifndef DLSC_AXI_ROUTER_COMMAND_PKG_SV
`define DLSC_AXI_ROUTER_COMMAND_PKG_SV

// Packs two per-sink windows into a MASKS/BASES vector, sink 1 in the upper slot.
`define DLSC_ROUTER_PACK2(W, S1, S0) {W'(S1), W'(S0)}

package dlsc_axi_router_command_pkg;

   // Width of a binary index over n entries; never narrower than one bit.
   function automatic int router_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

`endif

// File: rtl/dlsc_axi_router_command_decode.sv
// Address decoder: maps one source address onto a sink, lowest-index window wins,
// falling back to DEFAULT_SINK when no window matches.
module dlsc_axi_router_command_decode
   import dlsc_axi_router_command_pkg::*;
#(
   parameter int                    ADDR         = 32,
   parameter int                    SINKS        = 1,
   parameter int                    SINKSB       = router_clog2(SINKS),
   parameter logic [SINKS*ADDR-1:0] MASKS        = '0,
   parameter logic [SINKS*ADDR-1:0] BASES        = '0,
   parameter int                    DEFAULT_SINK = 0
) (
   input  logic [ADDR-1:0]   addr,
   output logic [SINKS-1:0]  sink_onehot,
   output logic [SINKSB-1:0] sink
);

   // Scanning downward lets the lowest matching index overwrite the others.
   always_comb begin
      sink = SINKSB'(DEFAULT_SINK);
      for (int k = SINKS - 1; k >= 0; k--) begin
         if ((addr & MASKS[k*ADDR +: ADDR]) == BASES[k*ADDR +: ADDR]) begin
            sink = SINKSB'(k);
         end
      end
      sink_onehot = '0;
      sink_onehot[sink] = 1'b1;
   end

endmodule

// File: rtl/dlsc_axi_router_command.sv
// Router address/command stage: decodes each source to a sink, grants one source
// per cycle round-robin, registers the address per sink and pushes the pairing.
module dlsc_axi_router_command
   import dlsc_axi_router_command_pkg::*;
#(
   parameter int                    ADDR         = 32,
   parameter int                    LEN          = 4,
   parameter int                    SOURCES      = 1,
   parameter int                    SOURCESB     = router_clog2(SOURCES),
   parameter int                    SINKS        = 1,
   parameter int                    SINKSB       = router_clog2(SINKS),
   parameter logic [SINKS*ADDR-1:0] MASKS        = '0,
   parameter logic [SINKS*ADDR-1:0] BASES        = '0,
   parameter int                    DEFAULT_SINK = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic [SOURCES-1:0]        in_ready,
   input  logic [SOURCES-1:0]        in_valid,
   input  logic [SOURCES*ADDR-1:0]   in_addr,
   input  logic [SOURCES*LEN-1:0]    in_len,
   input  logic [SINKS-1:0]          out_ready,
   output logic [SINKS-1:0]          out_valid,
   output logic [SINKS*ADDR-1:0]     out_addr,
   output logic [SINKS*LEN-1:0]      out_len,
   input  logic [SOURCES-1:0]        cmd_full_source,
   input  logic [SINKS-1:0]          cmd_full_sink,
   output logic                      cmd_push,
   output logic [SOURCES-1:0]        cmd_source_onehot,
   output logic [SINKS-1:0]          cmd_sink_onehot,
   output logic [SOURCESB-1:0]       cmd_source,
   output logic [SINKSB-1:0]         cmd_sink
);

   // Handshake: a source transfers on the cycle in_valid[j] && in_ready[j]; a sink
   // accepts on out_valid[k] && out_ready[k]; cmd_push marks the same source cycle.

   logic [SINKSB-1:0]   dec_sink    [SOURCES];
   logic [SINKS-1:0]    dec_onehot  [SOURCES];
   logic [SOURCES-1:0]  eligible;
   logic [SOURCESB-1:0] rr_ptr;
   logic [SOURCESB-1:0] grant_src;
   logic [SINKSB-1:0]   grant_sink;
   logic                grant;

   for (genvar j = 0; j < SOURCES; j++) begin : g_decode
      dlsc_axi_router_command_decode #(
         .ADDR         (ADDR),
         .SINKS        (SINKS),
         .SINKSB       (SINKSB),
         .MASKS        (MASKS),
         .BASES        (BASES),
         .DEFAULT_SINK (DEFAULT_SINK)
      ) u_decode (
         .addr        (in_addr[j*ADDR +: ADDR]),
         .sink_onehot (dec_onehot[j]),
         .sink        (dec_sink[j])
      );
   end

   // A sink slot is free if empty or being drained this very cycle.
   always_comb begin
      for (int j = 0; j < SOURCES; j++) begin
         eligible[j] = in_valid[j] && !cmd_full_source[j] && !cmd_full_sink[dec_sink[j]] &&
                       (!out_valid[dec_sink[j]] || out_ready[dec_sink[j]]);
      end
   end

   always_comb begin
      grant     = 1'b0;
      grant_src = '0;
      for (int i = 0; i < SOURCES; i++) begin
         int idx;
         idx = int'(rr_ptr) + i;
         if (idx >= SOURCES) idx = idx - SOURCES;
         if (!grant && !rst && eligible[idx]) begin
            grant     = 1'b1;
            grant_src = SOURCESB'(idx);
         end
      end
      grant_sink = dec_sink[grant_src];
   end

   always_comb begin
      in_ready          = '0;
      cmd_sink_onehot   = '0;
      cmd_sink          = '0;
      if (grant) begin
         in_ready[grant_src] = 1'b1;
         cmd_sink_onehot     = dec_onehot[grant_src];
         cmd_sink            = grant_sink;
      end
      cmd_push          = grant;
      cmd_source        = grant_src;
      cmd_source_onehot = in_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= '0;
         out_addr  <= '0;
         out_len   <= '0;
         rr_ptr    <= '0;
      end else begin
         for (int k = 0; k < SINKS; k++) begin
            if (grant && int'(grant_sink) == k) begin
               out_valid[k]             <= 1'b1;
               out_addr[k*ADDR +: ADDR] <= in_addr[int'(grant_src)*ADDR +: ADDR];
               out_len[k*LEN +: LEN]    <= in_len[int'(grant_src)*LEN +: LEN];
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
         if (grant) begin
            rr_ptr <= (int'(grant_src) == SOURCES - 1) ? '0 : grant_src + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dlsc_axi_router_command.sv
// Directed bench for the router command stage with two sources and two sinks,
// using expected-value queues checked by a negedge monitor.
module tb_dlsc_axi_router_command;

   localparam int ADDR = 32;
   localparam int LEN  = 4;
   localparam int NS   = 2;
   localparam int NK   = 2;
   localparam logic [NK*ADDR-1:0] MASKS_P = {32'h0000F000, 32'h0000F000};
   localparam logic [NK*ADDR-1:0] BASES_P = {32'h00001000, 32'h00000000};

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NS-1:0]        in_ready;
   logic [NS-1:0]        in_valid;
   logic [NS*ADDR-1:0]   in_addr;
   logic [NS*LEN-1:0]    in_len;
   logic [NK-1:0]        out_ready;
   logic [NK-1:0]        out_valid;
   logic [NK*ADDR-1:0]   out_addr;
   logic [NK*LEN-1:0]    out_len;
   logic [NS-1:0]        cmd_full_source;
   logic [NK-1:0]        cmd_full_sink;
   logic                 cmd_push;
   logic [NS-1:0]        cmd_source_onehot;
   logic [NK-1:0]        cmd_sink_onehot;
   logic                 cmd_source;
   logic                 cmd_sink;

   logic                 src_valid [NS];
   logic [ADDR-1:0]      src_addr  [NS];
   logic [LEN-1:0]       src_len   [NS];

   assign in_valid = {src_valid[1], src_valid[0]};
   assign in_addr  = {src_addr[1], src_addr[0]};
   assign in_len   = {src_len[1], src_len[0]};

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [1:0]  exp_cmd_q  [$];   // {source, sink}
   logic [35:0] exp_out0_q [$];   // {addr, len}
   logic [35:0] exp_out1_q [$];
   int          push_cyc_q [$];

   dlsc_axi_router_command #(
      .ADDR         (ADDR),
      .LEN          (LEN),
      .SOURCES      (NS),
      .SOURCESB     (1),
      .SINKS        (NK),
      .SINKSB       (1),
      .MASKS        (MASKS_P),
      .BASES        (BASES_P),
      .DEFAULT_SINK (0)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_addr           (in_addr),
      .in_len            (in_len),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_addr          (out_addr),
      .out_len           (out_len),
      .cmd_full_source   (cmd_full_source),
      .cmd_full_sink     (cmd_full_sink),
      .cmd_push          (cmd_push),
      .cmd_source_onehot (cmd_source_onehot),
      .cmd_sink_onehot   (cmd_sink_onehot),
      .cmd_source        (cmd_source),
      .cmd_sink          (cmd_sink)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input int j, input logic [ADDR-1:0] a, input logic [LEN-1:0] l);
      bit got;
      got          = 1'b0;
      src_valid[j] = 1'b1;
      src_addr[j]  = a;
      src_len[j]   = l;
      for (int t = 0; t < 40 && !got; t++) begin
         @(negedge clk);
         if (in_ready[j]) got = 1'b1;
      end
      if (!got) begin
         compared++;
         mismatched++;
         $display("FAIL send_timeout src%0d: in_ready stayed 0, expected 1", j);
      end
      @(posedge clk);
      #1;
      src_valid[j] = 1'b0;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [1:0]  e;
      logic [35:0] eo;
      cyc++;
      if (cmd_push) begin
         push_cyc_q.push_back(cyc);
         if (exp_cmd_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_push: got src %0d sink %0d, expected no push", cmd_source, cmd_sink);
         end else begin
            e = exp_cmd_q.pop_front();
            check("cmd_bin", {62'd0, cmd_source, cmd_sink}, {62'd0, e});
            check("cmd_source_onehot", {62'd0, cmd_source_onehot}, 64'd1 << e[1]);
            check("cmd_sink_onehot", {62'd0, cmd_sink_onehot}, 64'd1 << e[0]);
            check("in_ready_grant", {62'd0, in_ready}, 64'd1 << e[1]);
         end
      end else begin
         check("idle_outputs", {56'd0, in_ready, cmd_source_onehot, cmd_sink_onehot, cmd_source, cmd_sink}, 64'd0);
      end
      if (out_valid[0] && out_ready[0]) begin
         if (exp_out0_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_out0: got addr %0h, expected no transfer", out_addr[31:0]);
         end else begin
            eo = exp_out0_q.pop_front();
            check("out0_data", {28'd0, out_addr[31:0], out_len[3:0]}, {28'd0, eo});
         end
      end
      if (out_valid[1] && out_ready[1]) begin
         if (exp_out1_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_out1: got addr %0h, expected no transfer", out_addr[63:32]);
         end else begin
            eo = exp_out1_q.pop_front();
            check("out1_data", {28'd0, out_addr[63:32], out_len[7:4]}, {28'd0, eo});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int j = 0; j < NS; j++) begin
         src_valid[j] = 1'b0;
         src_addr[j]  = '0;
         src_len[j]   = '0;
      end
      out_ready       = 2'b11;
      cmd_full_source = '0;
      cmd_full_sink   = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", {62'd0, out_valid}, 64'd0);
      check("reset_out_addr", out_addr, 64'd0);
      check("reset_out_len", {56'd0, out_len}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // basic decode to sink 1
      exp_cmd_q.push_back({1'b0, 1'b1});
      exp_out1_q.push_back({32'h00001234, 4'h3});
      send(0, 32'h00001234, 4'h3);
      @(negedge clk);
      check("t1_out_valid", {62'd0, out_valid}, 64'd2);
      check("t1_out_addr1", {32'd0, out_addr[63:32]}, 64'h1234);
      @(posedge clk);
      #1;

      // unmatched address falls to the default sink
      exp_cmd_q.push_back({1'b1, 1'b0});
      exp_out0_q.push_back({32'h00008000, 4'h5});
      send(1, 32'h00008000, 4'h5);
      @(negedge clk);
      check("t5_default_sink", {62'd0, out_valid}, 64'd1);
      @(posedge clk);
      #1;

      // continuous requests alternate with no idle cycles
      exp_cmd_q.push_back({1'b0, 1'b0});
      exp_cmd_q.push_back({1'b1, 1'b1});
      exp_cmd_q.push_back({1'b0, 1'b0});
      exp_cmd_q.push_back({1'b1, 1'b1});
      exp_out0_q.push_back({32'h00000100, 4'h1});
      exp_out0_q.push_back({32'h00000200, 4'h2});
      exp_out1_q.push_back({32'h00001100, 4'h1});
      exp_out1_q.push_back({32'h00001200, 4'h2});
      fork
         begin
            send(0, 32'h00000100, 4'h1);
            send(0, 32'h00000200, 4'h2);
         end
         begin
            send(1, 32'h00001100, 4'h1);
            send(1, 32'h00001200, 4'h2);
         end
      join
      n = push_cyc_q.size();
      if (n >= 4) check("t2_no_bubble", 64'(push_cyc_q[n-1] - push_cyc_q[n-4]), 64'd3);
      else check("t2_push_count", 64'(n), 64'd4);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;

      // full sink flag holds off the grant
      cmd_full_sink = 2'b10;
      src_valid[0]  = 1'b1;
      src_addr[0]   = 32'h00001ABC;
      src_len[0]    = 4'h7;
      repeat (5) begin
         @(negedge clk);
         check("t3_stall_in_ready", {62'd0, in_ready}, 64'd0);
         check("t3_stall_push", {63'd0, cmd_push}, 64'd0);
      end
      @(posedge clk);
      #1;
      cmd_full_sink = 2'b00;
      exp_cmd_q.push_back({1'b0, 1'b1});
      exp_out1_q.push_back({32'h00001ABC, 4'h7});
      @(negedge clk);
      check("t3_release_grant", {62'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      src_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;

      // busy slot stalls, then drain and reload in one cycle
      out_ready = 2'b10;
      exp_cmd_q.push_back({1'b0, 1'b0});
      exp_out0_q.push_back({32'h00000400, 4'h4});
      send(0, 32'h00000400, 4'h4);
      src_valid[1] = 1'b1;
      src_addr[1]  = 32'h00000500;
      src_len[1]   = 4'h5;
      repeat (3) begin
         @(negedge clk);
         check("t4_stall_in_ready", {62'd0, in_ready}, 64'd0);
         check("t4_hold_valid", {63'd0, out_valid[0]}, 64'd1);
         check("t4_hold_addr", {32'd0, out_addr[31:0]}, 64'h400);
      end
      @(posedge clk);
      #1;
      out_ready = 2'b11;
      exp_cmd_q.push_back({1'b1, 1'b0});
      exp_out0_q.push_back({32'h00000500, 4'h5});
      @(negedge clk);
      check("t4_reload_ready", {62'd0, in_ready}, 64'd2);
      @(posedge clk);
      #1;
      src_valid[1] = 1'b0;
      @(negedge clk);
      check("t4_reload_valid", {63'd0, out_valid[0]}, 64'd1);
      check("t4_reload_addr", {32'd0, out_addr[31:0]}, 64'h500);
      @(posedge clk);
      #1;

      // reset with both slots full
      out_ready = 2'b00;
      exp_cmd_q.push_back({1'b1, 1'b1});
      exp_out1_q.push_back({32'h00001600, 4'h6});
      send(1, 32'h00001600, 4'h6);
      exp_cmd_q.push_back({1'b0, 1'b0});
      exp_out0_q.push_back({32'h00000600, 4'h6});
      send(0, 32'h00000600, 4'h6);
      src_valid[0] = 1'b1;
      src_addr[0]  = 32'h00000700;
      src_len[0]   = 4'h8;
      src_valid[1] = 1'b1;
      src_addr[1]  = 32'h00001700;
      src_len[1]   = 4'h9;
      out_ready    = 2'b11;
      rst          = 1'b1;
      @(negedge clk);
      check("t6_rst_push", {63'd0, cmd_push}, 64'd0);
      check("t6_rst_in_ready", {62'd0, in_ready}, 64'd0);
      @(negedge clk);
      check("t6_rst_out_valid", {62'd0, out_valid}, 64'd0);
      check("t6_rst_push2", {63'd0, cmd_push}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cmd_q.push_back({1'b0, 1'b0});
      exp_cmd_q.push_back({1'b1, 1'b1});
      exp_out0_q.push_back({32'h00000700, 4'h8});
      exp_out1_q.push_back({32'h00001700, 4'h9});
      @(negedge clk);
      check("t6_ptr_reset", {62'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      src_valid[0] = 1'b0;
      @(negedge clk);
      check("t6_second_grant", {62'd0, in_ready}, 64'd2);
      @(posedge clk);
      #1;
      src_valid[1] = 1'b0;
      repeat (3) @(negedge clk);

      check("end_cmd_q_empty", 64'(exp_cmd_q.size()), 64'd0);
      check("end_out0_q_empty", 64'(exp_out0_q.size()), 64'd0);
      check("end_out1_q_empty", 64'(exp_out1_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
